alu_logic_pipe: RTL

//  Pipelined, parametrised logic/compare/shift unit for the pipelined CPU's execute stage.

---
 rtl/alu_logic_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_logic_pipe.sv
// -----------------------------------------------------------------------------
// alu_logic_pipe
//   Pipelined logic / compare / shift unit for the CPU execute stage.
//   The operation is evaluated combinationally and registered into stage 1.
//   Stages 2..STAGES only delay it. A valid/ready handshake stalls the whole
//   pipe as one unit, flush kills every in-flight op, and a destination tag
//   travels alongside each result.
//
//   Optional feature macro: ALU_LOGIC_ROT_EN
//     defined   -> opsel 1001 = rotate left, 1010 = rotate right
//     undefined -> no rotator is built; 1001/1010 are illegal codes
// -----------------------------------------------------------------------------
module alu_logic_pipe #(
  parameter int WIDTH  = 32,  // operand/result width, >= 8, power of two
  parameter int STAGES = 2,   // accept-to-out_valid latency, 1..4
  parameter int TAG_W  = 5    // sideband tag width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [3:0]         opsel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               zero,
  output logic               illegal
);

  localparam int SH_W = $clog2(WIDTH);

  // Operation select codes.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
`ifdef ALU_LOGIC_ROT_EN
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv;     // every stage moves one place this edge
  logic accept;  // the op on the input port enters stage 1 this edge

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Combinational evaluation feeding stage 1
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]  sh;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] sra_val;

  assign sh          = op_b[SH_W-1:0];
  assign lt_signed   = $signed(op_a) < $signed(op_b);
  assign lt_unsigned = op_a < op_b;
  assign sra_val     = $signed(op_a) >>> sh;

`ifdef ALU_LOGIC_ROT_EN
  // Complementary shift distance for rotates. When sh = 0 this equals WIDTH,
  // the complementary shift yields zero, and the rotate returns op_a unchanged.
  logic [SH_W:0]    sh_inv;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;

  assign sh_inv  = (SH_W+1)'(WIDTH) - {1'b0, sh};
  assign rol_val = (op_a << sh) | (op_a >> sh_inv);
  assign ror_val = (op_a >> sh) | (op_a << sh_inv);
`endif

  logic [WIDTH-1:0] calc_res;
  logic             calc_ill;
  logic             calc_zero;

  // Select the operation result and flag undefined opcodes.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    calc_res = '0;
    calc_ill = 1'b0;
    unique case (opsel)
      OP_AND:  calc_res = op_a & op_b;
      OP_OR:   calc_res = op_a | op_b;
      OP_NOR:  calc_res = ~(op_a | op_b);
      OP_XOR:  calc_res = op_a ^ op_b;
      OP_SLT:  calc_res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: calc_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLL:  calc_res = op_a << sh;
      OP_SRL:  calc_res = op_a >> sh;
      OP_SRA:  calc_res = sra_val;
`ifdef ALU_LOGIC_ROT_EN
      OP_ROL:  calc_res = rol_val;
      OP_ROR:  calc_res = ror_val;
`endif
      default: begin
        calc_res = '0;
        calc_ill = 1'b1;
      end
    endcase
  end

  assign calc_zero = (calc_res == '0);

  // ---------------------------------------------------------------------------
  // Pipeline registers; index 0 is stage 1, index STAGES-1 drives the outputs
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][WIDTH-1:0]  res_q;
  logic [STAGES-1:0][TAG_W-1:0]  tag_q;
  logic [STAGES-1:0]             zero_q;
  logic [STAGES-1:0]             ill_q;

  // Valid bits: cleared by reset or flush; otherwise they shift on advance.
  // An empty slot stays empty as it moves, so bubbles are kept in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every stage reading the pre-edge value of its neighbour.
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data, tag and flags: loaded into stage 1 and shifted on advance, held on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data pipe is reset as well because the outputs it drives must read zero after reset.
      res_q  <= '0;
      tag_q  <= '0;
      zero_q <= '0;
      ill_q  <= '0;
    end else if (adv) begin
      res_q[0]  <= calc_res;
      tag_q[0]  <= in_tag;
      zero_q[0] <= calc_zero;
      ill_q[0]  <= calc_ill;
      for (int i = 1; i < STAGES; i++) begin
        res_q[i]  <= res_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        zero_q[i] <= zero_q[i-1];
        ill_q[i]  <= ill_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the last stage
  // ---------------------------------------------------------------------------
  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign zero      = zero_q[STAGES-1];
  assign illegal   = ill_q[STAGES-1];

endmodule
